lsu_ctrl: RTL
=============

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 64, max cycles spent in REQ+WAIT before abort.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mem_read  input  1  MEM-stage load request.
REQ-005 mem_write  input  1  MEM-stage store request.
REQ-006 mem_funct3  input  3  access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu).
REQ-007 mem_addr  input  32  byte address.
REQ-008 mem_wdata  input  32  store data, unaligned (LSBs).
REQ-009 dm_req  output  1  data-memory request, held until grant.
REQ-010 dm_addr  output  32  word-aligned address ({mem_addr[31:2],2'b00}).
REQ-011 dm_we  output  4  byte write strobes; 0000 for loads.
REQ-012 dm_wdata  output  32  lane-replicated store data.
REQ-013 dm_gnt  input  1  memory accepts request this cycle.
REQ-014 dm_rvalid  input  1  read data valid (no earlier than cycle after dm_gnt).
REQ-015 dm_rdata  input  32  raw read word.
REQ-016 stall  output  1  freeze IF..MEM pipeline registers.
REQ-017 ld_data  output  32  formatted load result.
REQ-018 ld_valid  output  1  one-cycle pulse, ld_data valid.
REQ-019 misalign  output  1  one-cycle misaligned-access flag.
REQ-020 bus_err  output  1  one-cycle timeout flag.

Function
REQ-021 FSM states IDLE, REQ, WAIT, DONE; one access outstanding at a time.
REQ-022 op = mem_read|mem_write; mem_write has priority when both set (treated as store).
REQ-023 Legal: w needs addr[1:0]=00; h/hu need addr[0]=0; b/bu any; store funct3 only 000/001/010.
REQ-024 IDLE, op legal: stall=1 combinationally; next cycle REQ with dm_addr/dm_we/dm_wdata/op registered.
REQ-025 IDLE, op misaligned: misalign=1 same cycle, stall=0, no request, stay IDLE.
REQ-026 IDLE, store with funct3 not in {000,001,010}: no-op, stall=0, no flag.
REQ-027 REQ: dm_req=1, stall=1; dm_addr/dm_we/dm_wdata stable until dm_gnt sampled high.
REQ-028 REQ+dm_gnt: store -> DONE; load -> WAIT; dm_req deasserts next cycle.
REQ-029 WAIT: stall=1; dm_rvalid -> capture formatted dm_rdata into ld_data, go DONE.
REQ-030 DONE: stall=0 (pipeline advances at this edge), ld_valid=1 for loads only, next state IDLE.
REQ-031 Store strobes: sb 0001<<addr[1:0], data {4{b}}; sh 0011<<{addr[1],1'b0}, data {2{h}}; sw 1111.
REQ-032 Load format: select byte addr[1:0] / half addr[1]; b/h sign-extend, bu/hu zero-extend, w unchanged; other funct3 -> 0.
REQ-033 Cycle counter clears on leaving IDLE, increments in REQ/WAIT; reaching TIMEOUT -> DONE, bus_err=1 that cycle, ld_data=0, dm_req dropped.
REQ-034 dm_rvalid outside WAIT ignored; ld_data holds last value outside DONE.
REQ-035 Min latency: store 3 cycles (IDLE, REQ w/ gnt, DONE); load 4 cycles with rvalid one cycle after gnt.

Reset
REQ-036 rst high at clk edge: state IDLE, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, ld_data=0, ld_valid=0, counter=0.
REQ-037 Reset mid-access aborts it; no ld_valid, late dm_rvalid after reset ignored.
REQ-038 While rst high, stall/misalign/bus_err are 0.

Verification
REQ-039 lw addr 0x100, gnt immediate, rvalid next cycle with 0x89ABCDEF -> stall 3 cycles, ld_valid with ld_data=0x89ABCDEF.
REQ-040 lb addr 0x103, rdata 0x80112233 -> ld_data=0xFFFFFF80; lbu same -> 0x00000080.
REQ-041 sh addr 0x22, wdata 0x0000BEEF, gnt delayed 5 cycles -> dm_we=1100, dm_wdata=0xBEEFBEEF, dm_addr=0x20 stable 5 cycles, stall until DONE.
REQ-042 lw addr 0x102 -> misalign=1 one cycle, dm_req never asserts, stall=0.
REQ-043 load, gnt given, no rvalid -> after TIMEOUT cycles bus_err=1, ld_data=0, FSM IDLE next cycle.
REQ-044 rst asserted in WAIT, rvalid next cycle -> no ld_valid, outputs at reset values.

Source files
------------

// File: rtl/lsu_ctrl.sv
// ============================================================================
// lsu_ctrl : single-outstanding load/store unit controller for the MEM stage
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        dm_req,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_we,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        misalign,
  output logic        bus_err
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          ld_op;
  logic          err_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;

  logic          op, fn_w, fn_h, store_bad, addr_bad, acc_start, acc_misalign;
  logic          tmo_hit, abort;
  logic [3:0]    st_we;
  logic [31:0]   st_wdata;

  function automatic logic [31:0] fmt_load(input logic [31:0] w,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b100:  fmt_load = {24'd0, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b101:  fmt_load = {16'd0, h};
      3'b010:  fmt_load = w;
      default: fmt_load = 32'd0;
    endcase
  endfunction

  // Request decode; a store with an unsupported size is silently dropped.
  always_comb begin
    op           = mem_read | mem_write;
    fn_w         = (mem_funct3 == 3'b010);
    fn_h         = (mem_funct3 == 3'b001) || (mem_funct3 == 3'b101);
    store_bad    = mem_write && !(mem_funct3 == 3'b000 || mem_funct3 == 3'b001 ||
                                  mem_funct3 == 3'b010);
    addr_bad     = (fn_w && (mem_addr[1:0] != 2'b00)) || (fn_h && mem_addr[0]);
    acc_start    = op && !store_bad && !addr_bad;
    acc_misalign = op && !store_bad && addr_bad;
  end

  always_comb begin
    st_we    = 4'b1111;
    st_wdata = mem_wdata;
    case (mem_funct3[1:0])
      2'b00: begin
        st_we    = 4'b0001 << mem_addr[1:0];
        st_wdata = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        st_we    = 4'b0011 << {mem_addr[1], 1'b0};
        st_wdata = {2{mem_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    dm_req    = 1'b0;
    misalign  = 1'b0;
    bus_err   = 1'b0;
    ld_valid  = 1'b0;
    tmo_hit   = (cnt >= TMO_LAST);
    abort     = 1'b0;
    case (state)
      IDLE: begin
        misalign = acc_misalign;
        if (acc_start) begin
          stall     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        dm_req = 1'b1;
        stall  = 1'b1;
        if (dm_gnt) begin
          state_nxt = ld_op ? WAIT : DONE;
        end else if (tmo_hit) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (dm_rvalid) begin
          state_nxt = DONE;
        end else if (tmo_hit) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end
      end
      default: begin
        ld_valid  = ld_op && !err_q;
        bus_err   = err_q;
        state_nxt = IDLE;
      end
    endcase
    if (rst) begin
      stall    = 1'b0;
      dm_req   = 1'b0;
      misalign = 1'b0;
      bus_err  = 1'b0;
      ld_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ld_op    <= 1'b0;
      err_q    <= 1'b0;
      f3_q     <= 3'd0;
      off_q    <= 2'd0;
      dm_addr  <= 32'd0;
      dm_we    <= 4'd0;
      dm_wdata <= 32'd0;
      ld_data  <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        cnt <= '0;
      end else if (state == REQ || state == WAIT) begin
        cnt <= cnt + CW'(1);
      end
      if (state == IDLE && acc_start) begin
        dm_addr  <= {mem_addr[31:2], 2'b00};
        dm_we    <= mem_write ? st_we : 4'd0;
        dm_wdata <= mem_write ? st_wdata : 32'd0;
        ld_op    <= !mem_write;
        f3_q     <= mem_funct3;
        off_q    <= mem_addr[1:0];
        err_q    <= 1'b0;
      end
      if (abort) begin
        err_q   <= 1'b1;
        ld_data <= 32'd0;
      end else if (state == WAIT && dm_rvalid) begin
        ld_data <= fmt_load(dm_rdata, f3_q, off_q);
      end
    end
  end

endmodule

`default_nettype wire
